pc_sequencer: RTL and testbench

Fetch sequencer that drives the 14-bit program counter of the RISC_8-bit core.
- Each cycle it reads the current `pc`, fetches the instruction word from program memory over a req/ack handshake, and hands it to the execute stage over valid/ready.
- It then issues the `update_pc` / `jump_enable` / `jump_addr` / `clear` controls that advance or redirect the counter.
- It decodes GOTO/CALL/RETURN locally and keeps an 8-entry hardware return stack.

---
 rtl/risc8_pkg.sv | 12 +
 rtl/pc_sequencer_if.sv | 15 +
 rtl/return_stack.sv | 69 ++++++
 rtl/pc_sequencer.sv | 93 +++++++++
 tb/tb_pc_sequencer.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/risc8_pkg.sv
// risc8_pkg: shared types and constants for the RISC_8-bit fetch path.
//   AW           program address / instruction width
//   OP_GOTO/CALL opcode field values in instr[13:11]
//   INSTR_RETURN full instruction word for RETURN
//   seq_state_t  fetch sequencer states
package risc8_pkg;
  localparam int AW = 14;
  localparam logic [2:0] OP_GOTO = 3'b101;
  localparam logic [2:0] OP_CALL = 3'b100;
  localparam logic [13:0] INSTR_RETURN = 14'h0008;
  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, ADVANCE} seq_state_t;
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: program-memory fetch bus plus execute-stage handoff.
//   mem_addr/mem_req  -> memory, mem_ack/mem_data <- memory
//   ex_instr/ex_valid -> execute stage, ex_ready <- execute stage
//   master: sequencer side, slave: memory/execute side
interface pc_sequencer_if #(parameter int AW = risc8_pkg::AW);
  logic [AW-1:0] mem_addr;
  logic mem_req;
  logic mem_ack;
  logic [AW-1:0] mem_data;
  logic [AW-1:0] ex_instr;
  logic ex_valid;
  logic ex_ready;
  modport master(output mem_addr, mem_req, ex_instr, ex_valid, input mem_ack, mem_data, ex_ready);
  modport slave(input mem_addr, mem_req, ex_instr, ex_valid, output mem_ack, mem_data, ex_ready);
endinterface

// File: rtl/return_stack.sv
// return_stack: circular hardware return stack.
//   clock, reset (async, active-low)
//   clr        empties the stack and clears err
//   push/pop   one operation per cycle, push_data written on push
//   top        most recent entry, 0 when empty
//   depth      occupied entries, saturates at DEPTH
//   err        sticky overflow/underflow flag
module return_stack import risc8_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int AW = risc8_pkg::AW,
  localparam int DW = $clog2(DEPTH + 1),
  localparam int SW = $clog2(DEPTH)
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic push,
  input  logic pop,
  input  logic [AW-1:0] push_data,
  output logic [AW-1:0] top,
  output logic [DW-1:0] depth,
  output logic err
);
  logic [AW-1:0] stk_q [DEPTH];
  logic [AW-1:0] stk_d [DEPTH];
  logic [SW-1:0] sp_q, sp_d;
  logic [DW-1:0] depth_q, depth_d;
  logic err_q, err_d;
  logic full, empty;
  assign full = depth_q == DW'(DEPTH);
  assign empty = depth_q == '0;
  // sp wraps modulo DEPTH, so a push when full lands on the oldest entry
  always_comb begin
    stk_d = stk_q;
    sp_d = sp_q;
    depth_d = depth_q;
    err_d = err_q;
    if (clr) begin
      sp_d = '0;
      depth_d = '0;
      err_d = 1'b0;
    end else if (push) begin
      stk_d[sp_q] = push_data;
      sp_d = sp_q + SW'(1);
      depth_d = full ? depth_q : depth_q + DW'(1);
      err_d = err_q | full;
    end else if (pop) begin
      sp_d = empty ? sp_q : sp_q - SW'(1);
      depth_d = empty ? depth_q : depth_q - DW'(1);
      err_d = err_q | empty;
    end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stk_q <= '{default: '0};
      sp_q <= '0;
      depth_q <= '0;
      err_q <= 1'b0;
    end else begin
      stk_q <= stk_d;
      sp_q <= sp_d;
      depth_q <= depth_d;
      err_q <= err_d;
    end
  end
  assign top = empty ? '0 : stk_q[sp_q - SW'(1)];
  assign depth = depth_q;
  assign err = err_q;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch sequencer driving the RISC_8-bit program counter.
//   clock, reset (async, active-low), start (level), sw_clear (sync soft clear)
//   pc                      current program counter
//   bus (master)            memory req/ack fetch and execute valid/ready handoff
//   update_pc/jump_enable/jump_addr/clear  counter controls
//   stack_depth/stack_err   return stack status
// Build option CALL_STACK_EN: adds the STACK_DEPTH-entry return stack with
// CALL push and RETURN pop; without it CALL acts as GOTO, RETURN increments.
module pc_sequencer import risc8_pkg::*; #(
  parameter int AW = risc8_pkg::AW
`ifdef CALL_STACK_EN
  , parameter int STACK_DEPTH = 8
`endif
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic sw_clear,
  input  logic [AW-1:0] pc,
  pc_sequencer_if.master bus,
  output logic update_pc,
  output logic jump_enable,
  output logic [AW-1:0] jump_addr,
  output logic clear,
  output logic [3:0] stack_depth,
  output logic stack_err
);
  seq_state_t state_q, state_d;
  logic [AW-1:0] instr_q, instr_d;
  logic adv, is_jmp;
  logic [AW-1:0] goto_addr;
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    if (sw_clear) state_d = IDLE;
    else begin
      case (state_q)
        IDLE: state_d = start ? FETCH : IDLE;
        FETCH: begin
          state_d = bus.mem_ack ? ISSUE : FETCH;
          instr_d = bus.mem_ack ? bus.mem_data : instr_q;
        end
        ISSUE: state_d = bus.ex_ready ? ADVANCE : ISSUE;
        default: state_d = FETCH;
      endcase
    end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
    end
  end
  // sw_clear masks the handshake outputs combinationally so they drop in its own cycle
  assign bus.mem_req = state_q == FETCH && !sw_clear;
  assign bus.mem_addr = bus.mem_req ? pc : '0;
  assign bus.ex_valid = state_q == ISSUE && !sw_clear;
  assign bus.ex_instr = instr_q;
  assign adv = state_q == ADVANCE && !sw_clear;
  assign update_pc = adv;
  assign clear = sw_clear;
  assign is_jmp = instr_q[AW-1 -: 3] == OP_GOTO || instr_q[AW-1 -: 3] == OP_CALL;
  assign goto_addr = {pc[AW-1 -: 3], instr_q[AW-4:0]};
`ifdef CALL_STACK_EN
  logic is_ret;
  logic [AW-1:0] ret_addr;
  logic [$clog2(STACK_DEPTH + 1)-1:0] depth;
  assign is_ret = instr_q == AW'(INSTR_RETURN);
  return_stack #(.DEPTH(STACK_DEPTH), .AW(AW)) u_stack (
    .clock(clock),
    .reset(reset),
    .clr(sw_clear),
    .push(adv && instr_q[AW-1 -: 3] == OP_CALL),
    .pop(adv && is_ret),
    .push_data(pc + AW'(1)),
    .top(ret_addr),
    .depth(depth),
    .err(stack_err)
  );
  // an empty stack reports top=0, which is the underflow redirect target
  assign jump_enable = adv && (is_jmp || is_ret);
  assign jump_addr = !adv ? '0 : is_jmp ? goto_addr : is_ret ? ret_addr : '0;
  assign stack_depth = 4'(depth);
`else
  assign jump_enable = adv && is_jmp;
  assign jump_addr = jump_enable ? goto_addr : '0;
  assign stack_depth = '0;
  assign stack_err = 1'b0;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: self-checking bench for pc_sequencer; the bench acts as
// program counter, memory and execute stage and predicts results from an
// instruction-level model with a queue-based return stack.
module tb_pc_sequencer;
`ifdef CALL_STACK_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif
  localparam int DEPTH = 8;
  logic clock, reset, start, sw_clear;
  logic [13:0] pc;
  logic update_pc, jump_enable, clear, stack_err;
  logic [13:0] jump_addr;
  logic [3:0] stack_depth;
  pc_sequencer_if #(.AW(14)) bus();
  pc_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .sw_clear(sw_clear), .pc(pc), .bus(bus),
    .update_pc(update_pc), .jump_enable(jump_enable), .jump_addr(jump_addr), .clear(clear),
    .stack_depth(stack_depth), .stack_err(stack_err)
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  int n_chk = 0;
  int n_fail = 0;
  logic [13:0] m_pc;
  logic m_err;
  logic [13:0] stk[$];
  logic [13:0] last_w;
  logic oje;
  logic [13:0] oja;
  typedef struct {
    logic [13:0] pc0;
    logic [13:0] w;
    logic je;
    logic [13:0] ja;
    logic [13:0] npc;
  } vec_t;
  vec_t tbl[8];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // one instruction at the spec level: redirect decision, stack effect, next pc
  task automatic model(input logic [13:0] w, output logic je, output logic [13:0] ja);
    logic [2:0] op;
    op = w[13:11];
    if (op == 3'b101 || op == 3'b100) begin
      if (STK && op == 3'b100) begin
        if (stk.size() == DEPTH) begin
          void'(stk.pop_front());
          m_err = 1'b1;
        end
        stk.push_back(m_pc + 14'd1);
      end
      je = 1'b1;
      ja = {m_pc[13:11], w[10:0]};
    end else if (STK && w == 14'h0008) begin
      je = 1'b1;
      if (stk.size() == 0) begin
        ja = 14'h0;
        m_err = 1'b1;
      end else ja = stk.pop_back();
    end else begin
      je = 1'b0;
      ja = 14'h0;
    end
    m_pc = je ? ja : m_pc + 14'd1;
  endtask
  task automatic model_clear();
    stk.delete();
    m_err = 1'b0;
    m_pc = 14'h0;
  endtask
  // one clock; the bench plays the program counter
  task automatic tick();
    logic u, je, cl;
    logic [13:0] ja;
    #1;
    u = update_pc;
    je = jump_enable;
    ja = jump_addr;
    cl = clear;
    @(posedge clock);
    #1;
    if (cl) pc = 14'h0;
    else if (u) pc = je ? ja : pc + 14'd1;
  endtask
  task automatic do_instr(input logic [13:0] w, input int ad, input int rd, output logic je_o, output logic [13:0] ja_o);
    logic eje;
    logic [13:0] eja;
    #1;
    chk("fetch_req", bus.mem_req, 1);
    chk("fetch_addr", bus.mem_addr, m_pc);
    model(w, eje, eja);
    repeat (ad) begin
      tick();
      chk("ack_stall_req", bus.mem_req, 1);
      chk("ack_stall_upd", update_pc, 0);
    end
    bus.mem_ack = 1'b1;
    bus.mem_data = w;
    tick();
    bus.mem_ack = 1'b0;
    bus.mem_data = 14'($urandom);
    chk("issue_valid", bus.ex_valid, 1);
    chk("issue_instr", bus.ex_instr, w);
    chk("issue_req", bus.mem_req, 0);
    repeat (rd) begin
      tick();
      chk("rdy_stall_valid", bus.ex_valid, 1);
      chk("rdy_stall_instr", bus.ex_instr, w);
      chk("rdy_stall_upd", update_pc, 0);
    end
    bus.ex_ready = 1'b1;
    tick();
    bus.ex_ready = 1'b0;
    chk("adv_upd", update_pc, 1);
    chk("adv_je", jump_enable, eje);
    chk("adv_ja", jump_addr, eja);
    chk("adv_valid", bus.ex_valid, 0);
    chk("adv_clear", clear, 0);
    je_o = jump_enable;
    ja_o = jump_addr;
    tick();
    chk("next_upd", update_pc, 0);
    chk("next_je", jump_enable, 0);
    chk("next_ja", jump_addr, 0);
    chk("next_pc", pc, m_pc);
    chk("next_req", bus.mem_req, 1);
    chk("depth", stack_depth, stk.size());
    chk("err", stack_err, m_err);
    last_w = w;
  endtask
  initial begin
    logic [13:0] w;
    tbl[0] = '{14'h0000, 14'h0123, 1'b0, 14'h0000, 14'h0001};
    tbl[1] = '{14'h0001, 14'h07FF, 1'b0, 14'h0000, 14'h0002};
    tbl[2] = '{14'h0002, 14'h3FFF, 1'b0, 14'h0000, 14'h0003};
    tbl[3] = '{14'h0003, 14'h1000, 1'b0, 14'h0000, 14'h0004};
    tbl[4] = '{14'h1805, 14'h2C12, 1'b1, 14'h1C12, 14'h1C12};
    tbl[5] = '{14'h3FFF, 14'h0000, 1'b0, 14'h0000, 14'h0000};
    tbl[6] = '{14'h2ABC, 14'h2800, 1'b1, 14'h2800, 14'h2800};
    tbl[7] = '{14'h0010, 14'h2100, 1'b1, 14'h0100, 14'h0100};
    reset = 1'b0;
    start = 1'b0;
    sw_clear = 1'b0;
    pc = 14'h0;
    bus.mem_ack = 1'b0;
    bus.mem_data = 14'h0;
    bus.ex_ready = 1'b0;
    last_w = 14'h0;
    model_clear();
    #2;
    chk("rst_req", bus.mem_req, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_valid", bus.ex_valid, 0);
    chk("rst_instr", bus.ex_instr, 0);
    chk("rst_upd", update_pc, 0);
    chk("rst_je", jump_enable, 0);
    chk("rst_ja", jump_addr, 0);
    chk("rst_clear", clear, 0);
    chk("rst_depth", stack_depth, 0);
    chk("rst_err", stack_err, 0);
    #4 reset = 1'b1;
    @(posedge clock);
    #1;
    chk("idle_req", bus.mem_req, 0);
    start = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      pc = tbl[i].pc0;
      m_pc = tbl[i].pc0;
      do_instr(tbl[i].w, 0, 0, oje, oja);
      chk("tbl_je", oje, tbl[i].je);
      chk("tbl_ja", oja, tbl[i].ja);
      chk("tbl_pc", pc, tbl[i].npc);
    end
    #2 reset = 1'b0;
    #1;
    chk("areset_req", bus.mem_req, 0);
    chk("areset_depth", stack_depth, 0);
    #1 reset = 1'b1;
    pc = 14'h0;
    model_clear();
    tick();
    pc = 14'h0010;
    m_pc = 14'h0010;
    do_instr(14'h2100, 0, 0, oje, oja);
    chk("call_ja", oja, 14'h0100);
    chk("call_depth", stack_depth, STK ? 1 : 0);
    do_instr(14'h0008, 0, 0, oje, oja);
    chk("ret_ja", oja, STK ? 14'h0011 : 14'h0000);
    chk("ret_depth", stack_depth, 0);
    for (int i = 0; i < 9; i++) do_instr({3'b100, 11'(i * 16 + 32)}, 0, 0, oje, oja);
    chk("ovf_err", stack_err, STK);
    chk("ovf_depth", stack_depth, STK ? 8 : 0);
    for (int i = 0; i < 8; i++) do_instr(14'h0008, 0, 0, oje, oja);
    do_instr(14'h0008, 0, 0, oje, oja);
    chk("unf_je", oje, STK);
    chk("unf_ja", oja, 0);
    do_instr(14'h0456, 5, 4, oje, oja);
    do_instr(14'h2ABC, 5, 4, oje, oja);
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 3))
        0: begin
          w = 14'($urandom) & 14'h1FFF;
          if (w == 14'h0008) w = 14'h0009;
        end
        1: w = {3'b101, 11'($urandom)};
        2: w = {3'b100, 11'($urandom)};
        default: w = 14'h0008;
      endcase
      do_instr(w, $urandom_range(0, 2), $urandom_range(0, 2), oje, oja);
    end
    do_instr(14'h2155, 0, 0, oje, oja);
    start = 1'b0;
    sw_clear = 1'b1;
    bus.mem_ack = 1'b1;
    bus.mem_data = 14'h2C12;
    #1;
    chk("swc_clear", clear, 1);
    chk("swc_req", bus.mem_req, 0);
    chk("swc_upd", update_pc, 0);
    chk("swc_valid", bus.ex_valid, 0);
    tick();
    sw_clear = 1'b0;
    bus.mem_ack = 1'b0;
    model_clear();
    #1;
    chk("swc_clear_end", clear, 0);
    chk("swc_idle_req", bus.mem_req, 0);
    chk("swc_idle_valid", bus.ex_valid, 0);
    chk("swc_instr", bus.ex_instr, last_w);
    chk("swc_depth", stack_depth, 0);
    chk("swc_err", stack_err, 0);
    chk("swc_pc", pc, m_pc);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    #1;
    chk("idle_ack_req", bus.mem_req, 0);
    chk("idle_ack_valid", bus.ex_valid, 0);
    chk("idle_ack_instr", bus.ex_instr, last_w);
    start = 1'b1;
    tick();
    do_instr(14'h0042, 1, 1, oje, oja);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
